// File: rtl/adc_scan_sequencer.sv
// Wishbone-configured ADC scan sequencer: paces conversions, guards against a hung
// converter with a timeout, and buffers 8-bit results in a FIFO with level/error interrupts.
module adc_scan_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [7:0]  adc_data,
  output logic        irq
);

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  localparam logic [2:0] OFS_CTRL   = 3'd0;
  localparam logic [2:0] OFS_PERIOD = 3'd1;
  localparam logic [2:0] OFS_STATUS = 3'd2;
  localparam logic [2:0] OFS_DATA   = 3'd3;
  localparam logic [2:0] OFS_THRESH = 3'd4;
  localparam logic [2:0] OFS_IE     = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_CONV
  } state_e;

  state_e          state_q;
  logic            adc_start_q;
  logic            pend_q;
  logic [TW-1:0]   wcnt_q;

  logic            en_q;
  logic            cont_q;
  logic [15:0]     period_q;
  logic [AW:0]     thresh_q;
  logic [2:0]      ie_q;
  logic            ovf_q;
  logic            to_q;

  logic [15:0]     cnt_q;
  logic [15:0]     cnt_d;
  logic            tick;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     level_q;
  logic [AW:0]     level_d;
  logic            empty;
  logic            full;
  logic [7:0]      head;

  logic            ack_q;
  logic [31:0]     dat_q;
  logic            irq_q;

  logic            acc;
  logic            wr;
  logic            rd;
  logic [2:0]      ofs;
  logic [31:0]     status;
  logic [31:0]     rdata;

  logic            clr;
  logic            pop;
  logic            conv_done;
  logic            conv_to;
  logic            push_ok;
  logic            ovf_set;
  logic            ss_clear;
  logic            irq_d;

  logic            unused_ok;

  assign unused_ok = ^{sel_i, adr_i[31:5], adr_i[1:0], dat_i[31:16]};

  assign acc = cyc_i & stb_i & ~ack_q;
  assign wr  = acc & we_i;
  assign rd  = acc & ~we_i;
  assign ofs = adr_i[4:2];

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);
  assign head  = mem[rd_ptr_q];

  assign clr       = wr & (ofs == OFS_CTRL) & dat_i[2];
  assign pop       = rd & (ofs == OFS_DATA) & ~empty;
  assign conv_done = (state_q == S_CONV) & adc_done;
  assign conv_to   = (state_q == S_CONV) & ~adc_done & (wcnt_q == TW'(TIMEOUT));
  // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
  assign push_ok   = conv_done & (~full | pop) & ~clr;
  assign ovf_set   = conv_done & full & ~pop & ~clr;
  assign ss_clear  = conv_done & ~cont_q;

  assign tick = en_q & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (!en_q || tick) begin
      cnt_d = period_q;
    end
  end

  always_comb begin
    level_d = level_q;
    if (clr) begin
      level_d = '0;
    end else if (push_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    status           = '0;
    status[AW:0]     = level_q;
    status[8]        = empty;
    status[9]        = full;
    status[10]       = ovf_q;
    status[11]       = to_q;
    status[12]       = (state_q != S_IDLE);
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_CTRL:   rdata = {30'd0, cont_q, en_q};
      OFS_PERIOD: rdata = {16'd0, period_q};
      OFS_STATUS: rdata = status;
      OFS_DATA:   rdata = empty ? 32'd0 : {24'd0, head};
      OFS_THRESH: rdata = 32'(thresh_q);
      OFS_IE:     rdata = {29'd0, ie_q};
      default:    rdata = '0;
    endcase
  end

  assign irq_d = (ie_q[0] & (level_q >= thresh_q) & (thresh_q != '0))
               | (ie_q[1] & ovf_q)
               | (ie_q[2] & to_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= acc;
      dat_q <= rd ? rdata : 32'd0;
      irq_q <= irq_d;
    end
  end

  // Configuration registers; a completed single-shot conversion drops EN after any bus write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      period_q <= '0;
      thresh_q <= '0;
      ie_q     <= '0;
    end else begin
      if (wr) begin
        case (ofs)
          OFS_CTRL: begin
            en_q   <= dat_i[0];
            cont_q <= dat_i[1];
          end
          OFS_PERIOD: period_q <= dat_i[15:0];
          OFS_THRESH: thresh_q <= dat_i[AW:0];
          OFS_IE:     ie_q     <= dat_i[2:0];
          default: ;
        endcase
      end
      if (ss_clear) begin
        en_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
      to_q  <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      if (wr && ofs == OFS_STATUS && dat_i[10]) ovf_q <= 1'b0;
      if (wr && ofs == OFS_STATUS && dat_i[11]) to_q  <= 1'b0;
      if (ovf_set) ovf_q <= 1'b1;
      if (conv_to) to_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Ticks that land while a conversion is in flight are remembered once and
  // served as soon as the FSM is back in IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      adc_start_q <= 1'b0;
      pend_q      <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          adc_start_q <= 1'b0;
          wcnt_q      <= '0;
          if (en_q && (tick || pend_q)) begin
            state_q     <= S_START;
            adc_start_q <= 1'b1;
            pend_q      <= 1'b0;
          end else if (!en_q) begin
            pend_q <= 1'b0;
          end
        end
        S_START: begin
          adc_start_q <= 1'b0;
          wcnt_q      <= '0;
          state_q     <= S_CONV;
          if (tick) pend_q <= 1'b1;
        end
        S_CONV: begin
          adc_start_q <= 1'b0;
          if (tick) pend_q <= 1'b1;
          if (adc_done || conv_to) begin
            state_q <= S_IDLE;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          adc_start_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= adc_data;
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign irq       = irq_q;
  assign adc_start = adc_start_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: bus-driven scenarios with a simple ADC responder.
module tb_adc_scan_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel_i = 4'hF;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        we_i = 1'b0;
  logic        ack_o;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [7:0]  adc_data = '0;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  int cyc_n = 0;
  int starts = 0;
  int last_cyc = 0;
  int last_gap = 0;
  int n_resp = 0;
  int stray_ack = 0;

  logic       adc_resp = 1'b1;
  logic [7:0] d_base = 8'h11;
  logic [7:0] d_step = 8'h11;
  int         d_mark = 0;
  int         stray_req = 0;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_PERIOD = 32'h04;
  localparam logic [31:0] A_STATUS = 32'h08;
  localparam logic [31:0] A_DATA   = 32'h0C;
  localparam logic [31:0] A_THRESH = 32'h10;
  localparam logic [31:0] A_IE     = 32'h14;

  adc_scan_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(255)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .sel_i     (sel_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .we_i      (we_i),
    .ack_o     (ack_o),
    .adc_start (adc_start),
    .adc_done  (adc_done),
    .adc_data  (adc_data),
    .irq       (irq)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  // ADC model: answers each start with a done pulse three edges later; can also
  // inject one stray done pulse on request.
  always @(posedge clk_i) begin
    #1;
    if (adc_start) begin
      starts   = starts + 1;
      last_gap = cyc_n - last_cyc;
      last_cyc = cyc_n;
      if (adc_resp) begin
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        adc_done = 1'b1;
        adc_data = 8'(int'(d_base) + int'(d_step) * (n_resp - d_mark));
        n_resp   = n_resp + 1;
        @(posedge clk_i);
        #1;
        adc_done = 1'b0;
      end
    end else if (stray_req != stray_ack) begin
      adc_done  = 1'b1;
      adc_data  = 8'h5A;
      stray_ack = stray_ack + 1;
      @(posedge clk_i);
      #1;
      adc_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    adr_i = a; dat_i = d; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk_i);
    #1;
    adr_i = a; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    d = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k = 0;
    while (starts < n && k < budget) begin
      @(posedge clk_i);
      #2;
      k++;
    end
    chk(tag, 32'(starts), 32'(n));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
  endtask

  initial begin
    int b;
    int k;

    // Reset state
    #2;
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_start", 32'(adc_start), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    cycles(3);
    #3;
    rst_n_i = 1'b1;
    rd_chk("rst_status", A_STATUS, 32'h100);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);

    // Continuous mode, period 10 cycles start-to-start
    d_base = 8'h11; d_step = 8'h11; d_mark = n_resp;
    wb_write(A_IE, 32'h0);
    wb_write(A_PERIOD, 32'd9);
    rd_chk("period_rb", A_PERIOD, 32'd9);
    wb_write(A_CTRL, 32'h3);
    wait_starts("cont_starts", 2, 100);
    wb_write(A_CTRL, 32'h0);
    chk("cont_gap", 32'(last_gap), 32'd10);
    cycles(12);
    chk("cont_no_more", 32'(starts), 32'd2);
    rd_chk("cont_lvl2", A_STATUS, 32'h002);
    rd_chk("cont_d0", A_DATA, 32'h11);
    rd_chk("cont_lvl1", A_STATUS, 32'h001);
    rd_chk("cont_d1", A_DATA, 32'h22);
    rd_chk("cont_lvl0", A_STATUS, 32'h100);
    rd_chk("empty_read", A_DATA, 32'h0);
    rd_chk("empty_stat", A_STATUS, 32'h100);
    rd_chk("unmapped", 32'h18, 32'h0);

    // Single-shot
    b = starts;
    wb_write(A_CTRL, 32'h1);
    wait_starts("ss_start", b + 1, 100);
    cycles(30);
    chk("ss_one", 32'(starts), 32'(b + 1));
    rd_chk("ss_en_clr", A_CTRL, 32'h0);
    rd_chk("ss_lvl", A_STATUS, 32'h001);
    rd_chk("ss_data", A_DATA, 32'h33);
    rd_chk("ss_empty", A_STATUS, 32'h100);

    // Overflow: 17 conversions into a 16-entry FIFO
    b = starts;
    d_base = 8'h01; d_step = 8'h01; d_mark = n_resp;
    wb_write(A_IE, 32'h2);
    wb_write(A_CTRL, 32'h3);
    wait_starts("ovf_starts", b + 17, 400);
    wb_write(A_CTRL, 32'h0);
    chk("ovf_gap", 32'(last_gap), 32'd10);
    cycles(5);
    chk("ovf_count", 32'(starts), 32'(b + 17));
    rd_chk("ovf_status", A_STATUS, 32'h610);
    chk("ovf_irq", 32'(irq), 32'd1);
    wb_write(A_STATUS, 32'h400);
    rd_chk("ovf_w1c", A_STATUS, 32'h210);
    chk("ovf_irq_clr", 32'(irq), 32'd0);
    rd_chk("ovf_d0", A_DATA, 32'h01);
    rd_chk("ovf_d1", A_DATA, 32'h02);
    rd_chk("ovf_lvl14", A_STATUS, 32'h00E);
    wb_write(A_CTRL, 32'h4);
    rd_chk("clr_flush", A_STATUS, 32'h100);

    // Timeout: converter never answers
    b = starts;
    adc_resp = 1'b0;
    wb_write(A_IE, 32'h4);
    wb_write(A_CTRL, 32'h3);
    wait_starts("to_start", b + 1, 100);
    cycles(196);
    rd_chk("to_busy", A_STATUS, 32'h1100);
    chk("to_inflight", 32'(starts), 32'(b + 1));
    cycles(100);
    rd_chk("to_flag", A_STATUS, 32'h1900);
    chk("to_restart", 32'(starts), 32'(b + 2));
    chk("to_irq", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h0);
    cycles(300);
    rd_chk("to_idle", A_STATUS, 32'h900);
    stray_req = stray_req + 1;
    cycles(6);
    rd_chk("stray_ign", A_STATUS, 32'h900);
    chk("to_nostart", 32'(starts), 32'(b + 2));
    wb_write(A_STATUS, 32'h800);
    rd_chk("to_w1c", A_STATUS, 32'h100);
    chk("to_irq_clr", 32'(irq), 32'd0);

    // Level threshold interrupt
    b = starts;
    adc_resp = 1'b1;
    d_base = 8'h11; d_step = 8'h11; d_mark = n_resp;
    wb_write(A_THRESH, 32'd4);
    wb_write(A_IE, 32'h1);
    wb_write(A_CTRL, 32'h3);
    wait_starts("th_starts", b + 4, 200);
    k = 0;
    while (!adc_done && k < 20) begin
      @(posedge clk_i);
      #2;
      k++;
    end
    chk("th_done_seen", 32'(adc_done), 32'd1);
    @(posedge clk_i);
    #2;
    chk("th_irq_lat", 32'(irq), 32'd0);
    @(posedge clk_i);
    #2;
    chk("th_irq_on", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h0);
    cycles(8);
    rd_chk("th_d0", A_DATA, 32'h11);
    cycles(2);
    chk("th_irq_off", 32'(irq), 32'd0);
    rd_chk("th_lvl3", A_STATUS, 32'h003);

    // Reset in the middle of a conversion
    wb_write(A_THRESH, 32'd1);
    cycles(2);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h3);
    k = 0;
    while (!adc_start && k < 100) begin
      @(posedge clk_i);
      #2;
      k++;
    end
    chk("pre_rst_start", 32'(adc_start), 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("arst_start", 32'(adc_start), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_ack", 32'(ack_o), 32'd0);
    cycles(2);
    #3;
    rst_n_i = 1'b1;
    rd_chk("arst_status", A_STATUS, 32'h100);
    rd_chk("arst_period", A_PERIOD, 32'h0);
    rd_chk("arst_ctrl", A_CTRL, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Wishbone-configured sequencer that triggers 8-bit ADC conversions at a programmable sample rate and buffers the results in a FIFO for the CPU. It sits between the Wishbone slave bus (its own address window) and the ADC macro's start/done conversion handshake. It enforces one conversion in flight and recovers from a hung converter by timeout. It raises an interrupt when the FIFO fill level reaches a threshold or an error occurs.

Parameters:
DEPTH, 16, FIFO entries (power of two, 4..64)
AW, 4, log2(DEPTH)
TIMEOUT, 255, maximum cycles from adc_start to adc_done before abort

Ports:
clk_i  input  1  system clock (single clock domain)
rst_n_i  input  1  asynchronous active-low reset
adr_i  input  32  Wishbone address (only [4:2] decoded)
dat_i  input  32  Wishbone write data
dat_o  output  32  Wishbone read data
sel_i  input  4  byte selects (ignored; full-word access)
cyc_i  input  1  Wishbone cycle
stb_i  input  1  Wishbone strobe (pre-decoded window select)
we_i  input  1  write enable
ack_o  output  1  Wishbone acknowledge
adc_start  output  1  one-cycle conversion request to ADC
adc_done  input  1  one-cycle conversion-complete pulse from ADC
adc_data  input  8  conversion result, valid when adc_done=1
irq  output  1  level interrupt

Behaviour:
- Reset (async, rst_n_i=0): all outputs 0 (ack_o, dat_o, adc_start, irq); CTRL=0, PERIOD=0, THRESH=0, flags cleared, FIFO empty, FSM IDLE, tick counter 0.
- Wishbone: access when cyc_i&stb_i&~ack_o; ack_o asserted exactly one cycle later for one cycle; dat_o registered with ack_o, 0 otherwise. Unmapped offsets: writes ignored, reads return 0.
- Register map (adr_i[4:2]):
  0x00 CTRL RW: [0] EN, [1] CONT (1=continuous, 0=single-shot), [2] CLR (write-1 pulse, reads 0: flush FIFO, clear OVF/TO).
  0x04 PERIOD RW [15:0]: sample period in clk cycles; effective period = max(PERIOD,1)+1... fixed rule: a conversion is requested every PERIOD+1 cycles, measured start-to-start, or on first free cycle after that if ADC busy.
  0x08 STATUS RO/W1C: [AW:0] level, [8] empty, [9] full, [10] OVF (W1C), [11] TO (W1C), [12] busy.
  0x0C DATA RO: read returns {24'b0, head}, pops one entry; read when empty returns 0, no pop, no flag.
  0x10 THRESH RW [AW:0]; IE RW at 0x14: [0] level IE, [1] OVF IE, [2] TO IE.
- Tick counter: reloads with PERIOD on EN 0->1 and on each tick; decrements while EN=1; tick when counter==0. EN=0 holds counter at PERIOD.
- FSM: IDLE -> (EN & tick) START; START: adc_start=1 one cycle -> CONV; CONV: on adc_done push adc_data, ->IDLE; if CONT=0 clear EN same cycle. CONV wait counter > TIMEOUT: set TO, -> IDLE, no push. Ticks arriving in START/CONV are held pending (1-deep) and served on return to IDLE; further ticks dropped.
- EN cleared mid-CONV: conversion completes and is stored; no new start.
- FIFO: push on adc_done in CONV only (adc_done outside CONV ignored). Push when full: data dropped, OVF=1. Simultaneous push and pop when full: both occur, no OVF. Pointers wrap modulo DEPTH; level 0..DEPTH.
- CLR same cycle as push: flush wins, sample discarded.
- irq = (IE[0] & level>=THRESH & THRESH!=0) | (IE[1]&OVF) | (IE[2]&TO), registered (1-cycle latency).

Test Plan:
- Reset: assert rst_n_i mid-conversion -> adc_start, ack_o, irq immediately 0; STATUS reads 0x100 after release.
- Continuous: PERIOD=9, CTRL=0x3, ADC responds 3 cycles after start with 0x11,0x22,... -> adc_start every 10 cycles; DATA reads return 0x11,0x22 in order; level decrements per read.
- Single-shot: CTRL=0x1 -> exactly one adc_start, EN reads 0 after done, level=1.
- Overflow: DEPTH=16, no reads, 17 conversions -> full=1, OVF=1, 17th sample lost; irq with IE=0x2; W1C of bit10 clears OVF and irq.
- Timeout: ADC never raises adc_done -> after 256 cycles TO=1, FSM IDLE, next tick issues new adc_start; stray adc_done in IDLE ignored.
- Threshold: THRESH=4, IE=1 -> irq rises one cycle after 4th push, falls after one DATA read.
